// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: shares one single-ported memory between the
// instruction-fetch requester and the data requester of a multicycle core.
// Flow per access: IDLE (grant + latch) -> ACCESS (hold until mem_ready or
// watchdog) -> DONE (one-cycle ready pulse to the owner) -> IDLE.
// Optional macro ARBITER_ROUND_ROBIN_EN: alternate grants on ties instead of
// the default fixed data-over-instruction priority.
module unified_memory_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int COUNTER_WIDTH  = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_address,
   output logic        inst_ready,
   output logic [31:0] inst_data,
   input  logic        data_mem_read_enable,
   input  logic        data_mem_write_enable,
   input  logic [31:0] data_mem_address,
   input  logic [31:0] data_mem_write_data,
   input  logic [2:0]  data_mem_width,
   output logic        data_ready,
   output logic [31:0] data_mem_data_fetched,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [2:0]  mem_width,
   output logic        mem_read_enable,
   output logic        mem_write_enable,
   input  logic [31:0] mem_data_fetched,
   input  logic        mem_ready,
   output logic        bus_error
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic OWN_DATA = 1'b0;
   localparam logic OWN_INST = 1'b1;

   // Watchdog fires on the TIMEOUT_CYCLES-th ACCESS cycle without mem_ready.
   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [COUNTER_WIDTH-1:0] WD_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [1:0]               state;
   logic                     owner;
   logic [COUNTER_WIDTH-1:0] counter;
   logic                     abort;
   logic                     data_req;
   logic                     grant_inst;
   logic                     finish_ok;
   logic                     finish_abort;

   assign data_req     = data_mem_read_enable | data_mem_write_enable;
   assign finish_ok    = (state == S_ACCESS) && mem_ready;
   assign finish_abort = (state == S_ACCESS) && !mem_ready && WD_EN && (counter == WD_LAST);

`ifdef ARBITER_ROUND_ROBIN_EN
   logic last_grant;

   // Tie goes to whichever requester was not granted last.
   always_comb begin
      grant_inst = inst_req;
      if (inst_req && data_req)
         grant_inst = (last_grant == OWN_DATA);
   end

   // Remember the most recent winner; starts as INST so data wins the first tie.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         last_grant <= OWN_INST;
      else if (state == S_IDLE && (inst_req || data_req))
         last_grant <= grant_inst ? OWN_INST : OWN_DATA;
   end
`else
   // Fixed priority: data beats instruction fetch.
   always_comb begin
      grant_inst = inst_req & ~data_req;
   end
`endif

   // Ready and error pulses are the DONE state decoded against the owner.
   assign inst_ready = (state == S_DONE) && (owner == OWN_INST);
   assign data_ready = (state == S_DONE) && (owner == OWN_DATA);
   assign bus_error  = (state == S_DONE) && abort;

   // Sequencing: grant in IDLE, wait/watchdog in ACCESS, single-cycle DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         owner   <= OWN_DATA;
         counter <= '0;
         abort   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (inst_req || data_req) begin
                  state   <= S_ACCESS;
                  owner   <= grant_inst ? OWN_INST : OWN_DATA;
                  counter <= '0;
                  abort   <= 1'b0;
               end
            end
            S_ACCESS: begin
               if (finish_ok) begin
                  state <= S_DONE;
                  abort <= 1'b0;
               end else if (finish_abort) begin
                  state <= S_DONE;
                  abort <= 1'b1;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Memory-side registers: latched on grant, held through ACCESS, enables
   // dropped as the access finishes (and asynchronously on reset).
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_address      <= '0;
         mem_write_data   <= '0;
         mem_width        <= '0;
         mem_read_enable  <= 1'b0;
         mem_write_enable <= 1'b0;
      end else if (state == S_IDLE && (inst_req || data_req)) begin
         if (grant_inst) begin
            mem_address      <= inst_address;
            mem_write_data   <= '0;
            mem_width        <= 3'b010;
            mem_read_enable  <= 1'b1;
            mem_write_enable <= 1'b0;
         end else begin
            mem_address      <= data_mem_address;
            mem_write_data   <= data_mem_write_data;
            mem_width        <= data_mem_width;
            // Read+write together is treated as a write.
            mem_read_enable  <= data_mem_read_enable & ~data_mem_write_enable;
            mem_write_enable <= data_mem_write_enable;
         end
      end else if (finish_ok || finish_abort) begin
         mem_read_enable  <= 1'b0;
         mem_write_enable <= 1'b0;
      end
   end

   // Response capture into the owner's register; aborted accesses return zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inst_data             <= '0;
         data_mem_data_fetched <= '0;
      end else if (finish_ok || finish_abort) begin
         if (owner == OWN_INST)
            inst_data <= finish_ok ? mem_data_fetched : 32'h0000_0000;
         else
            data_mem_data_fetched <= finish_ok ? mem_data_fetched : 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: transaction-level model plus a per-cycle
// compare process on the main instance, directed scenarios with literal
// expectations, a randomized traffic phase, and two auxiliary instances for
// the watchdog (TIMEOUT_CYCLES=4) and the disabled watchdog (TIMEOUT_CYCLES=0).
module tb_unified_memory_arbiter;

   localparam int TO = 8;

   logic        clock = 1'b0;
   logic        reset;
   always #5 clock = ~clock;

   // main instance signals
   logic        inst_req, inst_ready;
   logic [31:0] inst_address, inst_data;
   logic        data_mem_read_enable, data_mem_write_enable, data_ready;
   logic [31:0] data_mem_address, data_mem_write_data, data_mem_data_fetched;
   logic [2:0]  data_mem_width, mem_width;
   logic [31:0] mem_address, mem_write_data, mem_data_fetched;
   logic        mem_read_enable, mem_write_enable, mem_ready, bus_error;

   // auxiliary instances share inputs
   logic        a_ireq, a_rd, a_wr, a_ready;
   logic [31:0] a_iaddr, a_daddr, a_wdata, a_mdata;
   logic [2:0]  a_width;
   logic        w_iready, w_dready, w_rd, w_wr, w_err;
   logic [31:0] w_idata, w_ddata, w_addr, w_mwdata;
   logic [2:0]  w_width;
   logic        n_iready, n_dready, n_rd, n_wr, n_err;
   logic [31:0] n_idata, n_ddata, n_addr, n_mwdata;
   logic [2:0]  n_width;

   int tests = 0;
   int fails = 0;

   unified_memory_arbiter #(.TIMEOUT_CYCLES(TO), .COUNTER_WIDTH(8)) dut (
      .clock(clock), .reset(reset),
      .inst_req(inst_req), .inst_address(inst_address),
      .inst_ready(inst_ready), .inst_data(inst_data),
      .data_mem_read_enable(data_mem_read_enable), .data_mem_write_enable(data_mem_write_enable),
      .data_mem_address(data_mem_address), .data_mem_write_data(data_mem_write_data),
      .data_mem_width(data_mem_width), .data_ready(data_ready),
      .data_mem_data_fetched(data_mem_data_fetched),
      .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_width(mem_width),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
      .mem_data_fetched(mem_data_fetched), .mem_ready(mem_ready), .bus_error(bus_error)
   );

   unified_memory_arbiter #(.TIMEOUT_CYCLES(4), .COUNTER_WIDTH(8)) dut_wd (
      .clock(clock), .reset(reset),
      .inst_req(a_ireq), .inst_address(a_iaddr),
      .inst_ready(w_iready), .inst_data(w_idata),
      .data_mem_read_enable(a_rd), .data_mem_write_enable(a_wr),
      .data_mem_address(a_daddr), .data_mem_write_data(a_wdata),
      .data_mem_width(a_width), .data_ready(w_dready),
      .data_mem_data_fetched(w_ddata),
      .mem_address(w_addr), .mem_write_data(w_mwdata), .mem_width(w_width),
      .mem_read_enable(w_rd), .mem_write_enable(w_wr),
      .mem_data_fetched(a_mdata), .mem_ready(a_ready), .bus_error(w_err)
   );

   unified_memory_arbiter #(.TIMEOUT_CYCLES(0), .COUNTER_WIDTH(8)) dut_nowd (
      .clock(clock), .reset(reset),
      .inst_req(a_ireq), .inst_address(a_iaddr),
      .inst_ready(n_iready), .inst_data(n_idata),
      .data_mem_read_enable(a_rd), .data_mem_write_enable(a_wr),
      .data_mem_address(a_daddr), .data_mem_write_data(a_wdata),
      .data_mem_width(a_width), .data_ready(n_dready),
      .data_mem_data_fetched(n_ddata),
      .mem_address(n_addr), .mem_write_data(n_mwdata), .mem_width(n_width),
      .mem_read_enable(n_rd), .mem_write_enable(n_wr),
      .mem_data_fetched(a_mdata), .mem_ready(a_ready), .bus_error(n_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model of the main instance ----------
   // m_busy: an access is outstanding at the memory; m_done: the cycle the
   // owner is told the access finished. m_wait counts ACCESS cycles elapsed.
   bit          m_busy, m_done, m_abort, m_inst, m_wr, m_last_data;
   int          m_wait;
   logic [31:0] m_addr, m_wdata, m_idata, m_ddata;
   logic [2:0]  m_width;

   function automatic bit pick_inst(input bit ireq, input bit dreq, input bit last_data);
`ifdef ARBITER_ROUND_ROBIN_EN
      return ireq && (!dreq || last_data);
`else
      return ireq && !dreq;
`endif
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy <= 0; m_done <= 0; m_abort <= 0; m_inst <= 0; m_wr <= 0;
         m_last_data <= 0; m_wait <= 0;
         m_addr <= '0; m_wdata <= '0; m_width <= '0; m_idata <= '0; m_ddata <= '0;
      end else if (m_done) begin
         m_done <= 0;
      end else if (m_busy) begin
         if (mem_ready) begin
            m_busy <= 0; m_done <= 1; m_abort <= 0;
            if (m_inst) m_idata <= mem_data_fetched;
            else        m_ddata <= mem_data_fetched;
         end else if (TO != 0 && m_wait == TO - 1) begin
            m_busy <= 0; m_done <= 1; m_abort <= 1;
            if (m_inst) m_idata <= 32'h0;
            else        m_ddata <= 32'h0;
         end else begin
            m_wait <= m_wait + 1;
         end
      end else if (inst_req || data_mem_read_enable || data_mem_write_enable) begin
         if (pick_inst(inst_req, data_mem_read_enable | data_mem_write_enable, m_last_data)) begin
            m_inst <= 1; m_addr <= inst_address; m_width <= 3'b010; m_wr <= 0;
            m_last_data <= 0;
         end else begin
            m_inst <= 0; m_addr <= data_mem_address; m_width <= data_mem_width;
            m_wdata <= data_mem_write_data; m_wr <= data_mem_write_enable;
            m_last_data <= 1;
         end
         m_busy <= 1; m_wait <= 0;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clock) begin
      chk("mem_read_enable", mem_read_enable, m_busy && !m_wr);
      chk("mem_write_enable", mem_write_enable, m_busy && m_wr);
      if (m_busy) begin
         chk("mem_address", mem_address, m_addr);
         chk("mem_width", mem_width, m_width);
         if (m_wr) chk("mem_write_data", mem_write_data, m_wdata);
      end
      chk("inst_ready", inst_ready, m_done && m_inst);
      chk("data_ready", data_ready, m_done && !m_inst);
      chk("bus_error", bus_error, m_done && m_abort);
      chk("inst_data", inst_data, m_idata);
      chk("data_mem_data_fetched", data_mem_data_fetched, m_ddata);
   end

   // ---------------- stimulus ----------------
   task automatic clr_main();
      inst_req = 0; inst_address = '0;
      data_mem_read_enable = 0; data_mem_write_enable = 0;
      data_mem_address = '0; data_mem_write_data = '0; data_mem_width = '0;
      mem_ready = 0; mem_data_fetched = '0;
   endtask

   initial begin
      bit ok_wait;
      clr_main();
      a_ireq = 0; a_rd = 0; a_wr = 0; a_ready = 0;
      a_iaddr = '0; a_daddr = '0; a_wdata = '0; a_mdata = '0; a_width = '0;
      reset = 1;
      repeat (2) @(negedge clock);
      chk("rst_rd_en", mem_read_enable, 0);
      chk("rst_wr_en", mem_write_enable, 0);
      chk("rst_inst_data", inst_data, 0);
      chk("rst_data_fetched", data_mem_data_fetched, 0);
      chk("rst_addr", mem_address, 0);
      reset = 0;
      @(negedge clock);

      // Watchdog: a good read first so the zero on abort is observable.
      a_rd = 1; a_daddr = 32'h80; a_width = 3'b010;
      @(negedge clock);                       // ACCESS 1
      a_ready = 1; a_mdata = 32'h5A5A_5A5A;
      @(negedge clock);                       // DONE
      chk("wd_pre_ready", w_dready, 1);
      chk("wd_pre_data", w_ddata, 32'h5A5A_5A5A);
      chk("nowd_pre_ready", n_dready, 1);
      a_ready = 0;                            // request held: new access
      @(negedge clock);                       // IDLE
      chk("wd_idle_rd", w_rd, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("wd_access_rd", w_rd, 1);
         chk("wd_no_ready_early", w_dready, 0);
      end
      @(negedge clock);                       // DONE after 4 ACCESS cycles
      chk("wd_abort_rd_drop", w_rd, 0);
      chk("wd_abort_ready", w_dready, 1);
      chk("wd_abort_err", w_err, 1);
      chk("wd_abort_data", w_ddata, 0);
      a_rd = 0;
      ok_wait = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (n_rd !== 1'b1 || n_dready !== 1'b0 || n_err !== 1'b0) ok_wait = 0;
      end
      chk("nowd_waits_forever", ok_wait, 1);
      chk("wd_idle_after", w_rd, 0);

      // Instruction fetch, zero-wait memory.
      inst_req = 1; inst_address = 32'h0000_0040;
      @(negedge clock);
      chk("t1_rd_en", mem_read_enable, 1);
      chk("t1_width", mem_width, 3'b010);
      chk("t1_addr", mem_address, 32'h40);
      mem_ready = 1; mem_data_fetched = 32'h0000_0013;
      @(negedge clock);
      chk("t1_inst_ready", inst_ready, 1);
      chk("t1_inst_data", inst_data, 32'h13);
      chk("t1_data_ready", data_ready, 0);
      chk("t1_model_pin", m_idata, 32'h13);
      inst_req = 0; mem_ready = 0;
      @(negedge clock);
      chk("t1_pulse_once", inst_ready, 0);

      // Simultaneous requests: data first, then instruction.
      inst_req = 1; inst_address = 32'h100;
      data_mem_read_enable = 1; data_mem_address = 32'h200; data_mem_width = 3'b010;
      @(negedge clock);
      chk("t2_first_addr", mem_address, 32'h200);
      chk("t2_model_pin", m_inst, 0);
      mem_ready = 1; mem_data_fetched = 32'h1111_1111;
      @(negedge clock);
      chk("t2_data_ready", data_ready, 1);
      chk("t2_inst_not_ready", inst_ready, 0);
      chk("t2_data", data_mem_data_fetched, 32'h1111_1111);
      data_mem_read_enable = 0; mem_ready = 0;
      @(negedge clock);
      chk("t2_idle", mem_read_enable, 0);
      @(negedge clock);
      chk("t2_second_addr", mem_address, 32'h100);
      chk("t2_second_width", mem_width, 3'b010);
      mem_ready = 1; mem_data_fetched = 32'h2222_2222;
      @(negedge clock);
      chk("t2_inst_ready", inst_ready, 1);
      chk("t2_inst_data", inst_data, 32'h2222_2222);
      chk("t2_data_held", data_mem_data_fetched, 32'h1111_1111);
      inst_req = 0; mem_ready = 0;
      @(negedge clock);

      // Store with five wait states.
      data_mem_write_enable = 1; data_mem_address = 32'h2000;
      data_mem_write_data = 32'hDEAD_BEEF; data_mem_width = 3'b000;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         chk("t3_wr_en", mem_write_enable, 1);
         chk("t3_rd_en", mem_read_enable, 0);
         chk("t3_addr", mem_address, 32'h2000);
         chk("t3_wdata", mem_write_data, 32'hDEAD_BEEF);
         chk("t3_width", mem_width, 3'b000);
         chk("t3_no_ready", data_ready, 0);
         mem_ready = (k == 6);
      end
      @(negedge clock);
      chk("t3_ready", data_ready, 1);
      chk("t3_wr_drop", mem_write_enable, 0);
      data_mem_write_enable = 0; mem_ready = 0;
      @(negedge clock);
      chk("t3_ready_once", data_ready, 0);

      // Read and write together -> write.
      data_mem_read_enable = 1; data_mem_write_enable = 1;
      data_mem_address = 32'h3000; data_mem_write_data = 32'h1234_5678; data_mem_width = 3'b001;
      @(negedge clock);
      chk("t4_wr_en", mem_write_enable, 1);
      chk("t4_rd_en", mem_read_enable, 0);
      mem_ready = 1;
      @(negedge clock);
      chk("t4_ready", data_ready, 1);
      data_mem_read_enable = 0; data_mem_write_enable = 0; mem_ready = 0;
      @(negedge clock);

      // Reset mid-access.
      inst_req = 1; inst_address = 32'h300;
      @(negedge clock);
      chk("t5_access", mem_read_enable, 1);
      #2 reset = 1;
      #1;
      chk("t5_async_drop", mem_read_enable, 0);
      chk("t5_async_drop_nowd", n_rd, 0);
      inst_req = 0;
      @(negedge clock);
      chk("t5_no_ready", inst_ready, 0);
      reset = 0;
      inst_req = 1; inst_address = 32'h304; mem_ready = 1; mem_data_fetched = 32'h67;
      @(negedge clock);
      chk("t5_regrant", mem_read_enable, 1);
      chk("t5_regrant_addr", mem_address, 32'h304);
      @(negedge clock);
      chk("t5_inst_ready", inst_ready, 1);
      chk("t5_inst_data", inst_data, 32'h67);
      inst_req = 0; mem_ready = 0;
      @(negedge clock);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         if (inst_req) begin
            if (m_done && m_inst) begin
               if ($urandom_range(0, 1) == 0) inst_req = 0;
               else inst_address = $urandom & 32'hFFFF_FFFC;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            inst_req = 1; inst_address = $urandom & 32'hFFFF_FFFC;
         end
         if (data_mem_read_enable || data_mem_write_enable) begin
            if (m_done && !m_inst) begin
               data_mem_read_enable = 0; data_mem_write_enable = 0;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
               0:       begin data_mem_read_enable = 1; data_mem_write_enable = 0; end
               1:       begin data_mem_read_enable = 0; data_mem_write_enable = 1; end
               default: begin data_mem_read_enable = 1; data_mem_write_enable = 1; end
            endcase
            data_mem_address = $urandom;
            data_mem_write_data = $urandom;
            data_mem_width = 3'($urandom_range(0, 7));
         end
         mem_ready = ($urandom_range(0, 3) == 0);
         mem_data_fetched = $urandom;
      end
      clr_main();
      repeat (12) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester and its data requester.
- Used by the multicycle datapath, which has one memory port for both instructions and data.
- Latches the granted request, drives the memory with registered signals until the memory handshakes, then returns the response to the owner.
- A watchdog aborts accesses the memory never completes.

Parameters:
TIMEOUT_CYCLES, 64, cycles in ACCESS without mem_ready before abort; 0 disables the watchdog
COUNTER_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
inst_req  input  1  instruction fetch request, level, held until inst_ready
inst_address  input  32  fetch address, stable while inst_req
inst_ready  output  1  one-cycle pulse: inst_data valid
inst_data  output  32  fetched instruction
data_mem_read_enable  input  1  data read request
data_mem_write_enable  input  1  data write request
data_mem_address  input  32  data address, stable while requesting
data_mem_write_data  input  32  store data
data_mem_width  input  3  funct3-encoded access width
data_ready  output  1  one-cycle pulse: data access complete
data_mem_data_fetched  output  32  load result
mem_address  output  32  to memory
mem_write_data  output  32  to memory
mem_width  output  3  to memory
mem_read_enable  output  1  to memory
mem_write_enable  output  1  to memory
mem_data_fetched  input  32  from memory, valid with mem_ready on reads
mem_ready  input  1  memory completes the current access this cycle
bus_error  output  1  one-cycle pulse with the ready pulse of an aborted access

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-high; the port names are clock and reset.
- Reset values:
  - State is IDLE; owner is DATA; the counter is 0.
  - All outputs are 0, including inst_data and data_mem_data_fetched.
  - Memory enables drop immediately on reset assertion, including mid-access.
  - An in-flight access is lost with no ready pulse.
- Request definitions:
  - data request = data_mem_read_enable | data_mem_write_enable.
  - If both read and write are set, the access is a write; mem_read_enable stays 0.
- State IDLE:
  - Samples requests.
  - If neither requester is active, it stays in IDLE.
  - If one or both are active, it picks a winner (priority below) and latches the winner's address, width, write data and read/write into output registers.
  - Instruction fetch uses mem_width = 3'b010, write = 0, read = 1.
  - Next state is ACCESS; the counter clears.
- Priority (default build): data beats instruction when both are pending in IDLE.
- State ACCESS:
  - Memory outputs are held constant from the latched registers.
  - If mem_ready = 1: capture mem_data_fetched into the owner's data register and go to DONE. The capture happens for writes as well; the value is don't-care.
  - Else if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1: go to DONE with abort set. The owner's data register is loaded with 32'h0000_0000.
  - Otherwise the counter increments.
- State DONE:
  - Exactly one cycle.
  - Memory enables are 0.
  - The owner's ready pulses high; bus_error pulses if abort is set.
  - Requests are not sampled in DONE. The requester must drop or update its request on the edge that ends DONE.
  - Next state is IDLE.
- Latency and throughput:
  - Request sampled in IDLE at cycle N → memory enables high in cycle N+1.
  - mem_ready in cycle M → ready in cycle M+1 → IDLE in cycle M+2.
  - Minimum turnaround is 3 cycles per access (zero-wait memory).
- Other rules:
  - mem_ready outside ACCESS is ignored.
  - The non-owner's ready is never asserted.
  - The non-owner's data register holds its previous value.
  - A request that drops while in ACCESS does not cancel the access; completion is still signalled.

Optional Feature:
- Macro: ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A last_grant register, reset to INST, updates on every grant.
  - When both requests are pending in IDLE, the requester not in last_grant wins, so data wins the first tie after reset.
  - A single pending request always wins.
- Undefined: fixed data-over-instruction priority; no last_grant register.

Test Plan:
- Instruction fetch only, zero-wait memory:
  - Stimulus: inst_req=1, inst_address=32'h0000_0040; mem_ready=1 in the first ACCESS cycle with mem_data_fetched=32'h0000_0013.
  - Required: mem_read_enable high 1 cycle after the request; mem_width=3'b010; inst_ready pulses one cycle later with inst_data=32'h0000_0013; data_ready stays 0.
- Simultaneous requests, default build:
  - Stimulus: inst_req and data_mem_read_enable raised the same cycle.
  - Required: data granted first; instruction granted in the IDLE after data's DONE.
  - Same stimulus with ARBITER_ROUND_ROBIN_EN and requests held continuously: grants alternate DATA, INST, DATA, INST.
- Store with wait states:
  - Stimulus: data_mem_write_enable=1, address 32'h0000_2000, write data 32'hDEAD_BEEF, width 3'b000; mem_ready after 5 cycles.
  - Required: mem_write_enable held high for all 5+1 ACCESS cycles with outputs stable; mem_read_enable=0; data_ready pulses once.
- Read and write set together:
  - Stimulus: data_mem_read_enable=1 and data_mem_write_enable=1.
  - Required: mem_write_enable=1, mem_read_enable=0.
- Watchdog abort:
  - Stimulus: TIMEOUT_CYCLES=4; mem_ready never asserted.
  - Required: enables drop after 4 ACCESS cycles; data_ready and bus_error pulse together; data_mem_data_fetched=0.
  - With TIMEOUT_CYCLES=0: the access waits indefinitely.
- Reset mid-access:
  - Stimulus: assert reset while in ACCESS.
  - Required: mem_read_enable falls without waiting for a clock edge; no ready pulse; after release, an inst_req is granted normally.
